bin_argmax_seq: RTL and testbench
=================================

Name: bin_argmax_seq

Overview:
- Downstream consumer of the per-neuron binary popcount accumulators in the BNN output layer.
- Receives one popcount score per class, serially, over a valid/ready handshake.
- Tracks the running maximum and its class index.
- After C scores, presents the winning class (and its score) on an output valid/ready handshake, then re-arms for the next inference.

Parameters:
- N, 4, number of binary inputs per output neuron; sets score width SW = $clog2(N+1), matching the accumulator output width.
- C, 10, number of classes (scores per inference); must be >= 1. Index width CW = max(1, $clog2(C)).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  in_score valid this cycle
- in_ready  out  1  block accepts a score this cycle
- in_score  in  SW  popcount of current class, unsigned
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_class  out  CW  index (0..C-1) of winning class
- out_score  out  SW  winning popcount

Behaviour:
- Reset (async, rst=1): state=SCAN, idx=0, best_score=0, best_class=0, out_valid=0, in_ready=1, out_class=0, out_score=0. Reset mid-scan discards partial results; the next accepted score is treated as class 0.
- Accept event: in_valid && in_ready at a rising clk.
- State SCAN (in_ready=1, out_valid=0):
  - On accept with idx==0: best_score<=in_score, best_class<=0, unconditionally.
  - On accept with idx>0: if in_score > best_score (strictly, unsigned), then best_score<=in_score and best_class<=idx. Ties keep the earlier class, so the lowest index wins.
  - On accept with idx==C-1: apply the compare, set idx<=0, go to DONE. Otherwise idx<=idx+1.
  - No accept: all state is held.
- State DONE (in_ready=0, out_valid=1):
  - out_class and out_score are driven from registers and are stable while out_valid=1 && !out_ready.
  - On out_valid && out_ready: go to SCAN. best_score and best_class are retained but overwritten by the next idx==0 accept.
  - in_valid is ignored in DONE; no score is consumed.
- Latency: out_valid rises on the cycle after the C-th accept. With out_ready held high, DONE lasts 1 cycle; throughput is one result per C+1 cycles.
- C==1: every accept goes directly to DONE with out_class=0.
- Width: compare is at SW bits. in_score values above N (possible when N+1 is not a power of 2) are compared as-is, with no saturation.
- Outputs are registered; in_ready and out_valid decode from the state register only, with no combinational path from in_valid or out_ready.

Optional Feature:
- Macro BNN_ARGMAX_TIE_FLAG_EN.
- Defined: adds output port out_tie (1 bit). In DONE it is 1 if any score from another class equalled the final best_score. Implementation: a tie register cleared at idx==0 and on each strict replacement, set on equality. Its reset value is 0.
- Undefined: no port and no register. Tie handling (lowest index wins) is unchanged.

Decomposition:
- Shared package bnn_pkg holds:
  - score-width function SW(N) = $clog2(N+1), shared with the accumulator;
  - class-index width helper CW(C);
  - state enum {SCAN, DONE}.
- No sub-module needed; a single flat module is sufficient. The compare/update is a small always block.

Test Plan:
- N=4, C=4, scores 1,3,2,0 back-to-back, out_ready=1 -> out_valid 1 cycle after the 4th accept; out_class=1, out_score=3.
- Ties: scores 2,4,4,1 -> out_class=1, out_score=4. With BNN_ARGMAX_TIE_FLAG_EN, out_tie=1. Scores 0,0,0,0 -> out_class=0, out_score=0, out_tie=1.
- Backpressure: complete an inference, hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable, no scores consumed. Assert out_ready -> SCAN next cycle; the next inference is counted from class 0.
- Gapped input: in_valid toggles 1,0,0,1,... with scores 4,3,1,0 -> idx advances only on accept; out_class=0, out_score=4.
- Reset mid-scan: accept 2 scores (3,4), assert rst async mid-cycle, then feed 1,0,2,1 -> out_class=2, out_score=2. Outputs read 0 during reset.
- C=1: single accepted score 3 -> DONE next cycle; out_class=0, out_score=3.

Source files
------------

// File: rtl/bnn_pkg.sv
// ----------------------------------------------------------------------------
// bnn_pkg
//   Items shared across the BNN output layer (popcount accumulators and the
//   argmax stage that consumes their scores).
//
//   score_width(N) : width of a popcount over N binary inputs, $clog2(N+1).
//                    The accumulator output and the argmax score path both use
//                    this, so the two cannot drift apart.
//   class_width(C) : width of a class index 0..C-1. It is never less than 1,
//                    so that C==1 still yields a legal vector.
//   argmax_state_t : argmax sequencer states.
//                    SCAN = collecting scores.
//                    DONE = holding a result for the consumer.
// ----------------------------------------------------------------------------
package bnn_pkg;

    function automatic int score_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int class_width(input int c);
        return (c > 1) ? $clog2(c) : 1;
    endfunction

    typedef enum logic {
        SCAN = 1'b0,
        DONE = 1'b1
    } argmax_state_t;

endpackage

// File: rtl/bin_argmax_seq.sv
// ----------------------------------------------------------------------------
// bin_argmax_seq
//   Serial argmax over the C per-class popcount scores of one BNN inference.
//   Scores arrive one per accept, in class order (0..C-1). The block keeps the
//   running maximum and its class index. After the C-th score it presents the
//   winner on an output valid/ready handshake, then re-arms for the next
//   inference.
//
//   Ties keep the earlier class, so the lowest index wins. The compare is an
//   unsigned compare at the full score width. Values above N are compared
//   as they are, with no saturation.
//
// Parameters
//   N   binary inputs per output neuron; score width SW = $clog2(N+1)
//   C   classes per inference (C >= 1); index width CW = max(1, $clog2(C))
//
// Ports
//   clk        clock
//   rst        asynchronous, active-high reset
//   in_valid   in_score is valid this cycle
//   in_ready   block accepts a score this cycle (SCAN only)
//   in_score   popcount of the current class, unsigned
//   out_valid  result valid (DONE only)
//   out_ready  downstream accepts the result
//   out_class  index of the winning class
//   out_score  winning popcount
//   out_tie    (only with BNN_ARGMAX_TIE_FLAG_EN) another class equalled the
//              winning score
//
// Build option
//   BNN_ARGMAX_TIE_FLAG_EN  adds the out_tie port and its tracking register.
//
// in_ready and out_valid decode from the state register alone. There is no
// combinational path from in_valid or out_ready to any output.
// ----------------------------------------------------------------------------
module bin_argmax_seq
    import bnn_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int C  = 10,
    localparam int SW = score_width(N),
    localparam int CW = class_width(C)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [SW-1:0] in_score,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_class,
    output logic [SW-1:0] out_score
`ifdef BNN_ARGMAX_TIE_FLAG_EN
    ,
    output logic          out_tie
`endif
);

    localparam logic [CW-1:0] LAST_IDX = CW'(C - 1);

    argmax_state_t state, state_nxt;

    logic [CW-1:0] idx;
    logic [SW-1:0] best_score;
    logic [CW-1:0] best_class;

    logic accept;
    logic first;
    logic last;
    logic better;

    assign accept = in_valid && in_ready;
    assign first  = (idx == '0);
    assign last   = (idx == LAST_IDX);
    assign better = (in_score > best_score);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SCAN;
        else     state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            SCAN: if (accept && last) state_nxt = DONE;
            DONE: if (out_ready)      state_nxt = SCAN;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (pure decode of the state register)
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state == SCAN);
        out_valid = (state == DONE);
    end

    // ------------------------------------------------------------------
    // Running index and best score/class.
    // The first score of an inference loads the best score and class
    // without a compare. Whatever was left over from the previous
    // inference (or from reset) is therefore never used.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            best_score <= '0;
            best_class <= '0;
        end else if (accept) begin
            idx <= last ? '0 : idx + CW'(1);
            if (first) begin
                best_score <= in_score;
                best_class <= '0;
            end else if (better) begin
                best_score <= in_score;
                best_class <= idx;
            end
        end
    end

    assign out_class = best_class;
    assign out_score = best_score;

`ifdef BNN_ARGMAX_TIE_FLAG_EN
    // A new strict maximum invalidates any earlier tie. Once the final best
    // is established, any later equal score marks a tie against it.
    logic tie_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tie_q <= 1'b0;
        end else if (accept) begin
            if (first || better)              tie_q <= 1'b0;
            else if (in_score == best_score)  tie_q <= 1'b1;
        end
    end

    assign out_tie = tie_q;
`endif

endmodule

// File: tb/tb_bin_argmax_seq.sv
// ----------------------------------------------------------------------------
// tb_bin_argmax_seq
//   Self-checking bench for bin_argmax_seq.
//
//   dut  : N=4, C=4, used for the directed and random cases.
//   dut1 : N=4, C=1, used for the single-class case.
//
//   Inputs are driven at the falling edge and outputs are sampled there.
//   Expected results come from a reference model over the whole score list:
//   the maximum value, the first index holding it, and whether it occurs
//   more than once.
// ----------------------------------------------------------------------------
module tb_bin_argmax_seq;

    localparam int N  = 4;
    localparam int C  = 4;
    localparam int SW = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_score;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_class;
    logic [SW-1:0] out_score;

    logic          in_valid1;
    logic          in_ready1;
    logic [SW-1:0] in_score1;
    logic          out_valid1;
    logic          out_ready1;
    logic [0:0]    out_class1;
    logic [SW-1:0] out_score1;

`ifdef BNN_ARGMAX_TIE_FLAG_EN
    logic out_tie;
    logic out_tie1;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bin_argmax_seq #(.N(N), .C(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_score  (in_score),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_score (out_score)
`ifdef BNN_ARGMAX_TIE_FLAG_EN
        ,
        .out_tie   (out_tie)
`endif
    );

    bin_argmax_seq #(.N(N), .C(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_score  (in_score1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_class (out_class1),
        .out_score (out_score1)
`ifdef BNN_ARGMAX_TIE_FLAG_EN
        ,
        .out_tie   (out_tie1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: winner = first position holding the maximum value.
    function automatic void ref_argmax(input int sc[C], output int cls, output int best,
                                       output bit tie);
        int cnt;
        best = 0;
        foreach (sc[i]) if (sc[i] > best) best = sc[i];
        cls = -1;
        cnt = 0;
        foreach (sc[i]) if (sc[i] == best) begin
            if (cls < 0) cls = i;
            cnt++;
        end
        tie = (cnt > 1);
    endfunction

    // Idle for 'gap' cycles (in_valid low, junk score), then present one
    // score and return at the falling edge after it was taken.
    task automatic push(input int s, input int gap, input string tag);
        int t;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_score = 3'd7;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_score = SW'(s);
        t = 0;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("%s/in_ready", tag), in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Feed one inference with out_ready high, check the result, then check
    // the re-arm on the following cycle.
    task automatic run_inf(input int sc[C], input int maxgap, input string tag);
        int cls, best;
        bit tie;
        ref_argmax(sc, cls, best, tie);
        for (int i = 0; i < C; i++) begin
            push(sc[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, tag);
            if (i < C - 1) chk($sformatf("%s/early_valid%0d", tag, i), out_valid, 0);
        end
        chk($sformatf("%s/out_valid", tag), out_valid, 1);
        chk($sformatf("%s/out_class", tag), out_class, cls);
        chk($sformatf("%s/out_score", tag), out_score, best);
`ifdef BNN_ARGMAX_TIE_FLAG_EN
        chk($sformatf("%s/out_tie", tag), out_tie, tie);
`endif
        @(negedge clk);
        chk($sformatf("%s/rearm_valid", tag), out_valid, 0);
        chk($sformatf("%s/rearm_ready", tag), in_ready, 1);
    endtask

    initial begin
        int sc[C];
        int cls, best;
        bit tie;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_score   = '0;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        in_score1  = '0;
        out_ready1 = 1'b1;

        // Reset state
        #1;
        chk("rst/in_ready", in_ready, 1);
        chk("rst/out_valid", out_valid, 0);
        chk("rst/out_class", out_class, 0);
        chk("rst/out_score", out_score, 0);
        chk("rst/in_ready1", in_ready1, 1);
        #11 rst = 1'b0;
        @(negedge clk);

        // Basic case, back-to-back input
        sc = '{1, 3, 2, 0};
        run_inf(sc, 0, "basic");

        // Ties: the lowest index wins
        sc = '{2, 4, 4, 1};
        run_inf(sc, 0, "tie");
        sc = '{0, 0, 0, 0};
        run_inf(sc, 0, "zeros");

        // Backpressure. While DONE, a high score sits on the input; it must
        // not be consumed.
        out_ready = 1'b0;
        sc = '{1, 2, 3, 4};
        ref_argmax(sc, cls, best, tie);
        for (int i = 0; i < C; i++) push(sc[i], 0, "bp");
        in_valid = 1'b1;
        in_score = 3'd7;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp/in_ready%0d", k), in_ready, 0);
            chk($sformatf("bp/out_valid%0d", k), out_valid, 1);
            chk($sformatf("bp/out_class%0d", k), out_class, cls);
            chk($sformatf("bp/out_score%0d", k), out_score, best);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp/scan_ready", in_ready, 1);
        chk("bp/scan_valid", out_valid, 0);
        sc = '{1, 0, 0, 2};
        run_inf(sc, 0, "bp_next");

        // Gapped input: the index advances only when a score is accepted
        sc = '{4, 3, 1, 0};
        run_inf(sc, 3, "gap");

        // Reset mid-scan, asserted between clock edges
        push(3, 0, "mid");
        push(4, 0, "mid");
        #2 rst = 1'b1;
        #1;
        chk("mid/rst_out_score", out_score, 0);
        chk("mid/rst_out_class", out_class, 0);
        chk("mid/rst_out_valid", out_valid, 0);
        chk("mid/rst_in_ready", in_ready, 1);
        #1 rst = 1'b0;
        @(negedge clk);
        sc = '{1, 0, 2, 1};
        run_inf(sc, 0, "after_rst");

        // Random scores, including values above N, with random gaps
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < C; i++) sc[i] = int'($urandom_range(0, 7));
            run_inf(sc, (r % 3), $sformatf("rnd%0d", r));
        end

        // Single-class instance: every accepted score goes straight to DONE
        for (int r = 0; r < 3; r++) begin
            best = (r == 0) ? 3 : int'($urandom_range(0, 7));
            in_valid1 = 1'b1;
            in_score1 = SW'(best);
            chk($sformatf("c1_%0d/in_ready", r), in_ready1, 1);
            @(negedge clk);
            in_valid1 = 1'b0;
            chk($sformatf("c1_%0d/out_valid", r), out_valid1, 1);
            chk($sformatf("c1_%0d/out_class", r), out_class1, 0);
            chk($sformatf("c1_%0d/out_score", r), out_score1, best);
            @(negedge clk);
            chk($sformatf("c1_%0d/rearm", r), out_valid1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
